traffic_light_ctrl: RTL
=======================

# traffic_light_ctrl

Phase sequencer for a two-way (north-south / east-west) intersection. It steps through green, yellow and all-red phases using a built-in per-phase seconds down-counter, advanced by a one-per-second `tick` enable from the system prescaler. A latched pedestrian request can shorten the running green phase, and a night-mode input switches both directions to flashing yellow at a phase boundary. All light outputs and the remaining-seconds value for the display driver come from this block.

## Interface
- `pNS_GREEN`, 30, NS green duration in ticks (1..128)
- `pEW_GREEN`, 20, EW green duration in ticks (1..128)
- `pYELLOW`, 3, yellow duration in ticks (1..128), both directions
- `pALLRED`, 2, all-red clearance duration in ticks (1..128)
- `pPED_CUT`, 5, remaining-count ceiling applied to a green phase when a pedestrian request is pending; must be < min(`pNS_GREEN`, `pEW_GREEN`)
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous reset, active-low; reset is one clock domain, synchronous, active-low
- `tick`  in  1  one-cycle enable, one pulse per second
- `ped_req`  in  1  pedestrian button pulse or level, any length
- `night_mode`  in  1  level; request flashing-yellow operation
- `ns_red`, `ns_yellow`, `ns_green`  out  1 each  NS lamp drives
- `ew_red`, `ew_yellow`, `ew_green`  out  1 each  EW lamp drives
- `count`  out  7  seconds remaining in current phase, minus one
- `phase`  out  3  current state encoding
- `last`  out  1  `count == 0`, not in FLASH
- `ped_pending`  out  1  latched pedestrian request

## Operation
- States and encodings: NS_G=0, NS_Y=1, RED1=2, EW_G=3, EW_Y=4, RED2=5, FLASH=6. Encoding 7 is illegal and recovers to RED2 with `count`=`pALLRED`-1 on the next cycle.
- Normal sequence: NS_G→NS_Y→RED1→EW_G→EW_Y→RED2→NS_G.
- Phase entry loads `count` = duration-1. Each `tick` with `count`>0 decrements `count`. A `tick` with `count`==0 advances to the next state and loads its duration-1. Each phase therefore lasts exactly its duration in ticks.
- With no `tick`, state and `count` hold.
- Lamps are Moore-decoded from state, with exactly one lamp per direction:
  - NS_G: ns_green, ew_red
  - NS_Y: ns_yellow, ew_red
  - RED1, RED2: both red
  - EW_G: ew_green, ns_red
  - EW_Y: ew_yellow, ns_red
- Pedestrian handling:
  - `ped_req`=1 sets `ped_pending`.
  - `ped_pending` clears on any transition out of NS_G or EW_G.
  - If `ped_req`=1 in the same cycle as that clear, set wins.
  - In NS_G or EW_G, a `tick` with `ped_pending`=1 and `count`>`pPED_CUT` loads `count`=`pPED_CUT` instead of decrementing. If `count`≤`pPED_CUT`, the decrement is normal.
- Night mode:
  - `night_mode` is sampled only on an advancing tick (`tick` and `count`==0). If it is 1 there, the next state is FLASH instead of the normal successor.
  - In FLASH, `count` is held at 0, reds are off, `ns_yellow`=`ew_yellow`=flash bit, and the flash bit toggles on every `tick`. The flash bit is 1 on FLASH entry.
  - Exit happens on a `tick` with `night_mode`=0: go to RED2 with `count`=`pALLRED`-1, flash bit cleared.
  - `ped_pending` is cleared and ignored while in FLASH.
- Width rule: durations up to 128 fit `count` as duration-1 in 7 bits. No arithmetic wraps, because a decrement never occurs at 0.

## Timing
- Reset (synchronous, `rst_n`=0 at a `clk` edge): state NS_G, `count`=`pNS_GREEN`-1 (29), `ped_pending`=0, flash bit 0.
  - Reset-time outputs: `ns_green`=1, `ew_red`=1, all other lamps 0, `phase`=0, `last`=0.
  - Reset overrides `tick`, `ped_req` and `night_mode` in the same cycle. Reset mid-phase or in FLASH returns to the reset state on the next edge.
- State and `count` update one `clk` after the `tick` cycle. Lamps, `phase` and `last` follow state with no additional latency.
- `ped_pending` rises one clock after `ped_req`. A request in the same cycle as a `tick` takes effect at the next `tick`.
- Full cycle length with no requests: `pNS_GREEN`+`pEW_GREEN`+2·`pYELLOW`+2·`pALLRED` ticks = 60 ticks at defaults.

## Test plan
- Reset, then 60 ticks with no inputs → `phase` sequence 0(30 ticks),1(3),2(2),3(20),4(3),5(2), back to 0 with `count`=29; exactly one lamp per direction in every cycle.
- In NS_G with `count`=20, pulse `ped_req` → `ped_pending`=1; next tick gives `count`=5, then 5→0, then NS_Y; `ped_pending`=0 after the transition.
- `ped_req` while `count`=3 in EW_G → `count` keeps decrementing normally (2,1,0); `ped_pending` clears entering EW_Y. A second `ped_req` coinciding with that transition → `ped_pending` stays 1 into EW_Y.
- Assert `night_mode` mid NS_G → no change until `count`=0 tick, then FLASH: yellows toggle 1,0,1 per tick, reds off. Deassert `night_mode` → next tick enters RED2 (`count`=1), then NS_G with `count`=29.
- Hold `tick`=0 for 100 cycles mid-phase → state and `count` unchanged. Assert `rst_n`=0 in EW_Y or FLASH → next edge gives `phase`=0, `count`=29, `ped_pending`=0.
- Reset asserted in the same cycle as an advancing `tick` → reset state, no advance.

Source files
------------

// File: rtl/traffic_light_ctrl_if.sv
// rtl/traffic_light_ctrl_if.sv - control inputs and lamp/status outputs of the intersection sequencer
interface traffic_light_ctrl_if;
    logic       tick;
    logic       ped_req;
    logic       night_mode;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic [6:0] count;
    logic [2:0] phase;
    logic       last;
    logic       ped_pending;

    modport master (
        output tick, ped_req, night_mode,
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        input  count, phase, last, ped_pending
    );

    modport slave (
        input  tick, ped_req, night_mode,
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        output count, phase, last, ped_pending
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-way intersection phase sequencer with pedestrian cut and night flash
module traffic_light_ctrl #(
    parameter int pNS_GREEN = 30,
    parameter int pEW_GREEN = 20,
    parameter int pYELLOW   = 3,
    parameter int pALLRED   = 2,
    parameter int pPED_CUT  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_light_ctrl_if.slave  bus
);
    localparam logic [2:0] NS_G  = 3'd0;
    localparam logic [2:0] NS_Y  = 3'd1;
    localparam logic [2:0] RED1  = 3'd2;
    localparam logic [2:0] EW_G  = 3'd3;
    localparam logic [2:0] EW_Y  = 3'd4;
    localparam logic [2:0] RED2  = 3'd5;
    localparam logic [2:0] FLASH = 3'd6;
    localparam logic [2:0] BAD   = 3'd7;

    // Count reload values are duration-1 so that a phase spans exactly its duration in ticks.
    localparam logic [6:0] NS_G_LD = 7'(pNS_GREEN - 1);
    localparam logic [6:0] EW_G_LD = 7'(pEW_GREEN - 1);
    localparam logic [6:0] YEL_LD  = 7'(pYELLOW - 1);
    localparam logic [6:0] RED_LD  = 7'(pALLRED - 1);
    localparam logic [6:0] PED_CUT = 7'(pPED_CUT);

    logic [2:0] state;
    logic [6:0] count;
    logic       ped_pending;
    logic       flash;
    logic       in_green;
    logic       advance;
    logic [2:0] succ;
    logic [6:0] succ_ld;

    assign in_green = (state == NS_G) || (state == EW_G);
    assign advance  = bus.tick && (count == 7'd0);

    // Normal successor of each timed phase and the count it starts with.
    always_comb begin
        succ    = RED2;
        succ_ld = RED_LD;
        case (state)
            NS_G:    begin succ = NS_Y; succ_ld = YEL_LD;  end
            NS_Y:    begin succ = RED1; succ_ld = RED_LD;  end
            RED1:    begin succ = EW_G; succ_ld = EW_G_LD; end
            EW_G:    begin succ = EW_Y; succ_ld = YEL_LD;  end
            EW_Y:    begin succ = RED2; succ_ld = RED_LD;  end
            RED2:    begin succ = NS_G; succ_ld = NS_G_LD; end
            default: begin succ = RED2; succ_ld = RED_LD;  end
        endcase
    end

    // Phase state, seconds counter and flash bit advance only on tick; illegal state recovers to all-red.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= NS_G;
            count <= NS_G_LD;
            flash <= 1'b0;
        end else begin
            case (state)
                FLASH: begin
                    count <= 7'd0;
                    if (bus.tick) begin
                        if (!bus.night_mode) begin
                            state <= RED2;
                            count <= RED_LD;
                            flash <= 1'b0;
                        end else begin
                            flash <= ~flash;
                        end
                    end
                end
                BAD: begin
                    state <= RED2;
                    count <= RED_LD;
                    flash <= 1'b0;
                end
                default: begin
                    if (bus.tick) begin
                        if (count == 7'd0) begin
                            if (bus.night_mode) begin
                                state <= FLASH;
                                count <= 7'd0;
                                flash <= 1'b1;
                            end else begin
                                state <= succ;
                                count <= succ_ld;
                            end
                        end else if (in_green && ped_pending && (count > PED_CUT)) begin
                            count <= PED_CUT;
                        end else begin
                            count <= count - 7'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Pedestrian latch: a new request beats the clear that happens when a green phase ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
        end else if (state == FLASH) begin
            ped_pending <= 1'b0;
        end else if (bus.ped_req) begin
            ped_pending <= 1'b1;
        end else if (in_green && advance) begin
            ped_pending <= 1'b0;
        end
    end

    // Moore lamp decode: one lamp per direction, yellows only follow the flash bit in night mode.
    always_comb begin
        bus.ns_red    = 1'b0;
        bus.ns_yellow = 1'b0;
        bus.ns_green  = 1'b0;
        bus.ew_red    = 1'b0;
        bus.ew_yellow = 1'b0;
        bus.ew_green  = 1'b0;
        case (state)
            NS_G:    begin bus.ns_green  = 1'b1; bus.ew_red    = 1'b1; end
            NS_Y:    begin bus.ns_yellow = 1'b1; bus.ew_red    = 1'b1; end
            EW_G:    begin bus.ns_red    = 1'b1; bus.ew_green  = 1'b1; end
            EW_Y:    begin bus.ns_red    = 1'b1; bus.ew_yellow = 1'b1; end
            FLASH:   begin bus.ns_yellow = flash; bus.ew_yellow = flash; end
            default: begin bus.ns_red    = 1'b1; bus.ew_red    = 1'b1; end
        endcase
    end

    assign bus.count       = count;
    assign bus.phase       = state;
    assign bus.last        = (count == 7'd0) && (state != FLASH);
    assign bus.ped_pending = ped_pending;
endmodule
